// File: rtl/systolic_layer_ctrl_pkg.sv
// Shared state encoding and weight-load command codes for the systolic layer sequencer.
package systolic_pkg;

  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_LD_LO   = 4'd1,
    ST_WAIT_LO = 4'd2,
    ST_STR_LO  = 4'd3,
    ST_LD_HI   = 4'd4,
    ST_WAIT_HI = 4'd5,
    ST_STR_HI  = 4'd6,
    ST_CLR     = 4'd7,
    ST_RUN     = 4'd8,
    ST_DRAIN   = 4'd9,
    ST_RESULT  = 4'd10,
    ST_DONE    = 4'd11
  } state_e;

  localparam logic [2:0] WLOAD_IDLE = 3'b000;
  localparam logic [2:0] WLOAD_LO   = 3'b001;
  localparam logic [2:0] WLOAD_HI   = 3'b010;

endpackage

// File: rtl/systolic_layer_ctrl_delay_line.sv
// Parameterised 1-bit shift register; aligns mac_en with operands arriving from input memory.
module systolic_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr_q;

  generate
    if (DEPTH == 1) begin : g_one
      // single-stage delay
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= 1'b0;
        else        sr_q <= d;
      end
    end else begin : g_multi
      // multi-stage shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= {sr_q[DEPTH-2:0], d};
      end
    end
  endgenerate

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/systolic_layer_ctrl.sv
// Per-layer sequencer for the 4-MAC systolic array: weight load, input streaming, drain, result.
// Optional acknowledge watchdog enabled by defining SYSTOLIC_CTRL_TIMEOUT_EN.
module systolic_layer_ctrl
  import systolic_pkg::*;
#(
  parameter int N_MACS   = 4,
  parameter int CNT_W    = 8,
  parameter int LAYER_W  = 4,
  parameter int IN_LAT   = 2,
  parameter int PIPE_LAT = 3,
  parameter int TIMEOUT  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   cfg_num_inputs,
  input  logic [LAYER_W-1:0] cfg_num_layers,
  output logic               busy,
  output logic               done,
  output logic [2:0]         wt_load,
  input  logic               wt_load_ready,
  input  logic               wt_layer_ready,
  output logic               in_load_en,
  output logic               mac_clr,
  output logic               mac_en,
  output logic               acc_valid,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               err
);

  localparam logic [CNT_W-1:0] STR_LAST   = CNT_W'(N_MACS / 2 - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(IN_LAT + PIPE_LAT - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   num_q;
  logic [LAYER_W-1:0] layers_q;
  logic [LAYER_W-1:0] layer_idx_q;
  logic [2:0]         wt_load_q;
  logic               busy_q, done_q, in_load_en_q, mac_clr_q, acc_valid_q;

`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  localparam int WT_W = $clog2(TIMEOUT + 1);
  localparam logic [WT_W-1:0] WAIT_LAST = WT_W'(TIMEOUT - 1);
  logic [WT_W-1:0] wait_q;
  logic            err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Sequencer FSM; all outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      num_q        <= '0;
      layers_q     <= '0;
      layer_idx_q  <= '0;
      wt_load_q    <= WLOAD_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      in_load_en_q <= 1'b0;
      mac_clr_q    <= 1'b0;
      acc_valid_q  <= 1'b0;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
      wait_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      // level-sensitive downstream: commands and strobes default to one-cycle pulses
      wt_load_q   <= WLOAD_IDLE;
      mac_clr_q   <= 1'b0;
      acc_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            num_q       <= cfg_num_inputs;
            layers_q    <= cfg_num_layers;
            layer_idx_q <= '0;
            cnt_q       <= '0;
            if (cfg_num_layers == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_LD_LO;
              wt_load_q <= WLOAD_LO;
              busy_q    <= 1'b1;
            end
          end
        end
        ST_LD_LO: begin
          state_q <= ST_WAIT_LO;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
          wait_q  <= '0;
`endif
        end
        ST_WAIT_LO: begin
          if (wt_load_ready) begin
            state_q <= ST_STR_LO;
            cnt_q   <= '0;
          end
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
          else if (wait_q == WAIT_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + WT_W'(1);
          end
`endif
        end
        ST_STR_LO: begin
          if (cnt_q == STR_LAST) begin
            state_q   <= ST_LD_HI;
            wt_load_q <= WLOAD_HI;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_LD_HI: begin
          state_q <= ST_WAIT_HI;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
          wait_q  <= '0;
`endif
        end
        ST_WAIT_HI: begin
          if (wt_layer_ready) begin
            state_q <= ST_STR_HI;
            cnt_q   <= '0;
          end
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
          else if (wait_q == WAIT_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + WT_W'(1);
          end
`endif
        end
        ST_STR_HI: begin
          if (cnt_q == STR_LAST) begin
            state_q   <= ST_CLR;
            mac_clr_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_CLR: begin
          cnt_q <= '0;
          if (num_q == '0) begin
            state_q <= ST_DRAIN;
          end else begin
            state_q      <= ST_RUN;
            in_load_en_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cnt_q == num_q - CNT_W'(1)) begin
            state_q      <= ST_DRAIN;
            in_load_en_q <= 1'b0;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            state_q     <= ST_RESULT;
            acc_valid_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESULT: begin
          if (layer_idx_q == layers_q - LAYER_W'(1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            layer_idx_q <= layer_idx_q + LAYER_W'(1);
            state_q     <= ST_LD_LO;
            wt_load_q   <= WLOAD_LO;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  systolic_delay_line #(.DEPTH(IN_LAT)) u_mac_en_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_load_en_q),
    .q     (mac_en)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign wt_load    = wt_load_q;
  assign in_load_en = in_load_en_q;
  assign mac_clr    = mac_clr_q;
  assign acc_valid  = acc_valid_q;
  assign layer_idx  = layer_idx_q;

endmodule
